// File: rtl/flit_link_tx_pkg.sv
// Shared link definitions for both ends of a router-to-router flit link:
// flit width default, the flit type macro and the credit-width derivation.
`ifndef FLIT_LINK_TX_PKG_SV
`define FLIT_LINK_TX_PKG_SV

`define FLIT_LINK_FLIT_T(w) logic [(w)-1:0]

package flit_link_tx_pkg;

  localparam int FLIT_SIZE_DEF = 32;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // The counter must hold 0..depth inclusive, hence depth+1 codes.
  function automatic int credit_width(input int depth);
    return clogb2(depth + 1);
  endfunction

endpackage

`endif

// File: rtl/flit_link_tx_credit_counter.sv
// Saturating up/down credit counter: reset to MAX, one down per send,
// one up per returned credit; flags zero and over-return.
module flit_link_tx_credit_counter
  import flit_link_tx_pkg::*;
#(
  parameter int MAX = 8,
  localparam int W = credit_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  assign zero = (cnt == '0);
  // A credit arriving with nothing sent while already full has no slot to return to.
  assign ovf  = inc & ~dec & (cnt == MAX_C);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= MAX_C;
    end else if (inc && !dec && !ovf) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/flit_link_tx.sv
// Upstream end of a router link with credit-based flow control.
// Optional macro FLIT_LINK_TX_ERR_EN adds a sticky credit-overflow flag err_o.
module flit_link_tx
  import flit_link_tx_pkg::*;
#(
  parameter int FLIT_SIZE = FLIT_SIZE_DEF,
  parameter int BUFFER_SIZE = 8,
  localparam int CREDIT_W = credit_width(BUFFER_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  `FLIT_LINK_FLIT_T(FLIT_SIZE) data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output `FLIT_LINK_FLIT_T(FLIT_SIZE) data_o,
  output logic                       valid_o,
  input  logic                       credit_i,
  output logic [CREDIT_W-1:0]        credits_o
`ifdef FLIT_LINK_TX_ERR_EN
  ,
  output logic                       err_o
`endif
);

  logic send;
  logic zero;
`ifdef FLIT_LINK_TX_ERR_EN
  logic ovf;
`else
  logic ovf_unused;
`endif

  assign ready_o = ~zero;
  assign send    = valid_i & ready_o;

  flit_link_tx_credit_counter #(
    .MAX (BUFFER_SIZE)
  ) u_credit_counter (
    .clk  (clk),
    .rst  (rst),
    .dec  (send),
    .inc  (credit_i),
    .cnt  (credits_o),
    .zero (zero),
`ifdef FLIT_LINK_TX_ERR_EN
    .ovf  (ovf)
`else
    .ovf  (ovf_unused)
`endif
  );

  // data_o only loads on a send so the link wires stay quiet when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      valid_o <= send;
      if (send) data_o <= data_i;
    end
  end

`ifdef FLIT_LINK_TX_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else if (ovf) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_link_tx.sv
// Self-checking bench for flit_link_tx: directed scenarios then random traffic
// against a credit-count reference model.
module tb_flit_link_tx;

  localparam int FW = 32;
  localparam int BS = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [FW-1:0] data_i;
  logic          valid_i;
  logic          ready_o;
  logic [FW-1:0] data_o;
  logic          valid_o;
  logic          credit_i;
  logic [CW-1:0] credits_o;
`ifdef FLIT_LINK_TX_ERR_EN
  logic          err_o;
`endif

  flit_link_tx #(
    .FLIT_SIZE   (FW),
    .BUFFER_SIZE (BS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .credit_i  (credit_i),
    .credits_o (credits_o)
`ifdef FLIT_LINK_TX_ERR_EN
    ,
    .err_o     (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int            m_cnt = BS;
  logic          m_valid = 1'b0;
  logic [FW-1:0] m_data = '0;
  logic          m_err = 1'b0;
  logic          m_sent = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check ready before the edge, advance the model, check after.
  task automatic step(input logic v, input logic [FW-1:0] d, input logic c, input logic r);
    int nxt;
    rst      = r;
    valid_i  = v;
    data_i   = d;
    credit_i = c;
    #1;
    if (r) chk("ready", 64'(ready_o), 64'(m_cnt != 0));
    if (!r) begin
      m_cnt   = BS;
      m_valid = 1'b0;
      m_data  = '0;
      m_err   = 1'b0;
      m_sent  = 1'b0;
    end else begin
      m_sent = v && (m_cnt > 0);
      nxt = m_cnt - (m_sent ? 1 : 0) + (c ? 1 : 0);
      if (nxt > BS) begin
        nxt = BS;
        m_err = 1'b1;
      end
      m_cnt   = nxt;
      m_valid = m_sent;
      if (m_sent) m_data = d;
    end
    @(posedge clk);
    #1;
    chk("valid", 64'(valid_o), 64'(m_valid));
    chk("data", 64'(data_o), 64'(m_data));
    chk("credits", 64'(credits_o), 64'(m_cnt));
`ifdef FLIT_LINK_TX_ERR_EN
    chk("err", 64'(err_o), 64'(m_err));
`endif
  endtask

  initial begin
    logic          pend;
    logic [FW-1:0] pend_d;
    logic          v, c, r;
    logic [FW-1:0] d;

    rst = 1'b0; valid_i = 1'b0; data_i = '0; credit_i = 1'b0;
    @(posedge clk); #1;

    // reset held for two cycles
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_credits", 64'(credits_o), 64'(BS));
    chk("reset_ready", 64'(ready_o), 64'd1);

    // burst of 9 flits with no credits returned; 0x9 stalls
    for (int i = 1; i <= 9; i++) step(1, FW'(i), 0, 1);
    chk("burst_empty_ready", 64'(ready_o), 64'd0);

    // credit return lets the held flit go
    step(1, 9, 1, 1);
    chk("cr_credits", 64'(credits_o), 64'd1);
    step(1, 9, 0, 1);
    chk("cr_send_data", 64'(data_o), 64'h9);

    // refill to 3 then send and return in the same cycle
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(1, 32'hAA, 1, 1);
    chk("simul_credits", 64'(credits_o), 64'd3);

    // refill to full, then an illegal extra credit
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    chk("ovf_sat", 64'(credits_o), 64'(BS));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // drain to 2 credits with a flit on the wire, then reset
    for (int i = 0; i < 6; i++) step(1, FW'(32'h100 + i), 0, 1);
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    step(1, 32'h200, 0, 0);
    chk("mid_rst_credits", 64'(credits_o), 64'(BS));
    chk("mid_rst_valid", 64'(valid_o), 64'd0);

    // random traffic; a stalled flit is held stable until accepted
    pend = 1'b0;
    pend_d = '0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 79) != 0);
      if (pend) begin
        v = 1'b1;
        d = pend_d;
      end else begin
        v = ($urandom_range(0, 2) != 0);
        d = $urandom;
      end
      if (m_cnt < BS) c = ($urandom_range(0, 2) == 0);
      else            c = ($urandom_range(0, 24) == 0);
      step(v, d, c, r);
      pend   = r && v && !m_sent;
      pend_d = d;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
